// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - ctrl_state_e : sequencer FSM state encodings
//   - FWD_*        : EX-stage operand forwarding select codes
//   - fwd_hit()    : one producer/consumer forwarding match
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_IO_WAIT  = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hard-wired to zero, so a write to it is never a forwarding source.
    function automatic logic fwd_hit(input logic       regwrite,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        return regwrite && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational EX-stage operand forwarding selects.
// Ports:
//   i_ex_rs1_addr, i_ex_rs2_addr : source registers of the EX instruction
//   i_mem_rd_addr, i_mem_regwrite: destination / write enable in MEM
//   i_wb_rd_addr,  i_wb_regwrite : destination / write enable in WB
//   o_fwd_a, o_fwd_b             : FWD_RF / FWD_WB / FWD_MEM
// ---------------------------------------------------------------------------
module forwarding_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_rs1_addr,
    input  logic [4:0] i_ex_rs2_addr,
    input  logic [4:0] i_mem_rd_addr,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_wb_rd_addr,
    input  logic       i_wb_regwrite,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    // MEM holds the younger result, so it wins over WB when both match.
    always_comb begin
        o_fwd_a = FWD_RF;
        if (fwd_hit(i_mem_regwrite, i_mem_rd_addr, i_ex_rs1_addr))
            o_fwd_a = FWD_MEM;
        else if (fwd_hit(i_wb_regwrite, i_wb_rd_addr, i_ex_rs1_addr))
            o_fwd_a = FWD_WB;

        o_fwd_b = FWD_RF;
        if (fwd_hit(i_mem_regwrite, i_mem_rd_addr, i_ex_rs2_addr))
            o_fwd_b = FWD_MEM;
        else if (fwd_hit(i_wb_regwrite, i_wb_rd_addr, i_ex_rs2_addr))
            o_fwd_b = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencer for the IF_ID / ID_EX / EX_MEM / MEM_WB pipeline
// registers: load-use bubble, taken-branch flush, whole-pipeline freeze for
// multi-cycle memory reads and button-confirmed MMIO reads, EX forwarding
// selects and saturating stall/flush performance counters.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ID_* / EX_* / MEM_* / WB_* : register addresses and control of each stage
//   conf_btn_out        : synchronised confirm button
//   perf_clr            : synchronous clear of both counters
//   PC_stall .. MEM_WB_flush : per-register stall / flush controls
//   fwd_a, fwd_b        : EX operand forwarding selects
//   ctrl_state          : sequencer state (debug)
//   stall_cycles, flush_cycles : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [4:0]       EX_rs1_addr,
    input  logic [4:0]       EX_rs2_addr,
    input  logic [4:0]       EX_rd_addr,
    input  logic             EX_MemRead,
    input  logic             EX_ioRead,
    input  logic             EX_branch_taken,
    input  logic [4:0]       MEM_rd_addr,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic             MEM_ioRead,
    input  logic [4:0]       WB_rd_addr,
    input  logic             WB_RegWrite,
    input  logic             conf_btn_out,
    input  logic             perf_clr,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    // A load spends MEM_LAT cycles in MEM: one frozen cycle in RUN, then
    // MEM_LAT-2 frozen cycles in MEM_WAIT, then the release cycle.
    localparam bit         MULTI_CYCLE = (MEM_LAT >= 2);
    localparam int         WAIT_INIT_I = MULTI_CYCLE ? (MEM_LAT - 2) : 0;
    localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_conf_prev;
    logic             w_io_rise;
    logic             w_freeze;
    logic             w_load_use;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_cycles;

    assign w_io_rise = conf_btn_out & ~r_conf_prev;

    assign w_load_use = (EX_MemRead | EX_ioRead) && (EX_rd_addr != 5'd0) &&
                        ((ID_uses_rs1 && (ID_rs1_addr == EX_rd_addr)) ||
                         (ID_uses_rs2 && (ID_rs2_addr == EX_rd_addr)));

    // ---- FSM state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CTRL_RUN;
            r_cnt       <= 4'd0;
            r_conf_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_conf_prev <= conf_btn_out;
        end
    end

    // ---- FSM next state and freeze ----
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_freeze    = 1'b0;
        unique case (r_state)
            CTRL_RUN: begin
                if (MEM_ioRead) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = CTRL_IO_WAIT;
                end else if (MEM_MemRead && MULTI_CYCLE) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = CTRL_MEM_WAIT;
                    w_cnt_nxt   = WAIT_INIT;
                end
            end
            CTRL_MEM_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_freeze  = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = CTRL_RUN;
                end
            end
            CTRL_IO_WAIT: begin
                // The read data is taken in the rise cycle itself.
                if (w_io_rise)
                    w_state_nxt = CTRL_RUN;
                else
                    w_freeze = 1'b1;
            end
            default: w_state_nxt = CTRL_RUN;
        endcase
    end

    // ---- Hazard priority: freeze > branch > load-use ----
    // Gated by rst so every control drops the moment reset asserts, even
    // while MEM still presents a load.
    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        if (rst) begin
            PC_stall = 1'b0;
        end else if (w_freeze) begin
            // EX is held, so a taken branch there is re-evaluated on release.
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_load_use) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
        end
    end

    forwarding_unit u_fwd (
        .i_ex_rs1_addr  (EX_rs1_addr),
        .i_ex_rs2_addr  (EX_rs2_addr),
        .i_mem_rd_addr  (MEM_rd_addr),
        .i_mem_regwrite (MEM_RegWrite),
        .i_wb_rd_addr   (WB_rd_addr),
        .i_wb_regwrite  (WB_RegWrite),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );

    assign fwd_a      = rst ? FWD_RF : w_fwd_a;
    assign fwd_b      = rst ? FWD_RF : w_fwd_b;
    assign ctrl_state = r_state;

    // ---- Performance counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else if (perf_clr) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (PC_stall)
                r_stall_cycles <= sat_inc(r_stall_cycles);
            if (IF_ID_flush)
                r_flush_cycles <= sat_inc(r_flush_cycles);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed checks of the hazard controller with MEM_LAT=4 and CNT_W=4.
// Controls are compared as a packed vector
// {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
//  EX_MEM_stall, MEM_WB_flush}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_BRANCH = 7'b0010100;
    localparam logic [6:0] C_LDUSE  = 7'b1100100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1_addr, ID_rs2_addr, EX_rs1_addr, EX_rs2_addr, EX_rd_addr;
    logic [4:0] MEM_rd_addr, WB_rd_addr;
    logic       ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_ioRead, EX_branch_taken;
    logic       MEM_RegWrite, MEM_MemRead, MEM_ioRead, WB_RegWrite;
    logic       conf_btn_out, perf_clr;
    logic       PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic       EX_MEM_stall, MEM_WB_flush;
    logic [1:0] fwd_a, fwd_b, ctrl_state;
    logic [3:0] stall_cycles, flush_cycles;
    logic [6:0] ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                  EX_MEM_stall, MEM_WB_flush};

    pipeline_hazard_ctrl #(.MEM_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rs1_addr(EX_rs1_addr), .EX_rs2_addr(EX_rs2_addr),
        .EX_rd_addr(EX_rd_addr), .EX_MemRead(EX_MemRead), .EX_ioRead(EX_ioRead),
        .EX_branch_taken(EX_branch_taken),
        .MEM_rd_addr(MEM_rd_addr), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemRead(MEM_MemRead), .MEM_ioRead(MEM_ioRead),
        .WB_rd_addr(WB_rd_addr), .WB_RegWrite(WB_RegWrite),
        .conf_btn_out(conf_btn_out), .perf_clr(perf_clr),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_flush(MEM_WB_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs1_addr = 0; ID_rs2_addr = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        EX_rs1_addr = 0; EX_rs2_addr = 0; EX_rd_addr = 0;
        EX_MemRead = 0; EX_ioRead = 0; EX_branch_taken = 0;
        MEM_rd_addr = 0; MEM_RegWrite = 0; MEM_MemRead = 0; MEM_ioRead = 0;
        WB_rd_addr = 0; WB_RegWrite = 0; perf_clr = 0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1; EX_rd_addr = 5; ID_rs1_addr = 5; ID_uses_rs1 = 1;
    endtask

    initial begin
        clear_inputs();
        conf_btn_out = 0;
        rst = 1;
        // Reset: controls and forwarding forced low even with a live hazard.
        MEM_ioRead = 1; MEM_RegWrite = 1; MEM_rd_addr = 3; EX_rs1_addr = 3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_state", 32'(ctrl_state), 0);
        check("rst_stall_cnt", 32'(stall_cycles), 0);
        check("rst_flush_cnt", 32'(flush_cycles), 0);
        clear_inputs();
        #1 rst = 0;

        // Load-use on rs1: one bubble cycle.
        set_load_use();
        #1 check("lduse_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        check("lduse_cnt", 32'(stall_cycles), 1);
        EX_MemRead = 0;
        #1 check("lduse_one_cycle", 32'(ctl), 32'(C_NONE));
        // Same with rd = x0: no hazard.
        EX_MemRead = 1; EX_rd_addr = 0; ID_rs1_addr = 0;
        #1 check("lduse_x0", 32'(ctl), 32'(C_NONE));
        tick();
        check("lduse_x0_cnt", 32'(stall_cycles), 1);
        // MMIO load feeding rs2.
        clear_inputs();
        EX_ioRead = 1; EX_rd_addr = 9; ID_rs2_addr = 9; ID_uses_rs2 = 1;
        #1 check("iouse_rs2", 32'(ctl), 32'(C_LDUSE));
        tick();
        check("iouse_cnt", 32'(stall_cycles), 2);
        ID_uses_rs2 = 0;
        #1 check("iouse_unused_rs2", 32'(ctl), 32'(C_NONE));

        // Branch beats a simultaneous load-use.
        clear_inputs();
        set_load_use();
        EX_branch_taken = 1;
        #1 check("branch_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        check("branch_flush_cnt", 32'(flush_cycles), 1);
        check("branch_stall_cnt", 32'(stall_cycles), 2);
        clear_inputs();

        // Multi-cycle load, MEM_LAT=4: states 0,1,1,1,0, freeze for 3 cycles.
        MEM_MemRead = 1;
        #1 check("mem_c1_state", 32'(ctrl_state), 0);
        check("mem_c1_ctl", 32'(ctl), 32'(C_FREEZE));
        tick();
        EX_branch_taken = 1;
        #1 check("mem_c2_state", 32'(ctrl_state), 1);
        check("mem_c2_ctl_branch_ignored", 32'(ctl), 32'(C_FREEZE));
        tick();
        EX_branch_taken = 0;
        #1 check("mem_c3_state", 32'(ctrl_state), 1);
        check("mem_c3_ctl", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("mem_c4_state", 32'(ctrl_state), 1);
        check("mem_c4_release", 32'(ctl), 32'(C_NONE));
        tick();
        MEM_MemRead = 0;
        #1 check("mem_c5_state", 32'(ctrl_state), 0);
        check("mem_c5_ctl", 32'(ctl), 32'(C_NONE));
        check("mem_stall_cnt", 32'(stall_cycles), 5);
        check("mem_flush_cnt", 32'(flush_cycles), 1);

        // MMIO read: 10 frozen cycles with button low, release on the rise.
        MEM_ioRead = 1;
        for (int i = 0; i < 10; i++) begin
            #1 check($sformatf("io_freeze_%0d", i), 32'(ctl), 32'(C_FREEZE));
            tick();
        end
        check("io_wait_state", 32'(ctrl_state), 2);
        conf_btn_out = 1;
        #1 check("io_release", 32'(ctl), 32'(C_NONE));
        tick();
        check("io_back_run", 32'(ctrl_state), 0);
        check("io_stall_sat", 32'(stall_cycles), 15);
        // Following MMIO read with the button still held: no re-release.
        #1 check("io2_freeze", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("io2_state", 32'(ctrl_state), 2);
        check("io2_held_no_rise", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("io2_still_frozen", 32'(ctl), 32'(C_FREEZE));

        // Reset mid-wait: immediate return to RUN, controls drop at once.
        rst = 1;
        #1 check("rst_mid_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_mid_state", 32'(ctrl_state), 0);
        check("rst_mid_cnt", 32'(stall_cycles), 0);
        clear_inputs();
        conf_btn_out = 0;
        tick();
        rst = 0;

        // Forwarding.
        MEM_rd_addr = 7; WB_rd_addr = 7; EX_rs1_addr = 7;
        MEM_RegWrite = 1; WB_RegWrite = 1;
        #1 check("fwd_a_mem", 32'(fwd_a), 2);
        MEM_RegWrite = 0;
        #1 check("fwd_a_wb", 32'(fwd_a), 1);
        EX_rs2_addr = 7; MEM_RegWrite = 1;
        #1 check("fwd_b_mem", 32'(fwd_b), 2);
        MEM_rd_addr = 0; WB_rd_addr = 0; EX_rs2_addr = 0;
        #1 check("fwd_b_x0", 32'(fwd_b), 0);
        MEM_rd_addr = 7; WB_rd_addr = 7; MEM_RegWrite = 0; WB_RegWrite = 0;
        #1 check("fwd_a_none", 32'(fwd_a), 0);
        clear_inputs();

        // Counter saturation and clear priority.
        set_load_use();
        perf_clr = 1;
        tick();
        check("clr_wins", 32'(stall_cycles), 0);
        perf_clr = 0;
        repeat (20) tick();
        check("sat_stall", 32'(stall_cycles), 15);
        perf_clr = 1;
        tick();
        check("clr_stall", 32'(stall_cycles), 0);
        check("clr_flush", 32'(flush_cycles), 0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It produces per-register stall and flush controls and the EX-stage forwarding selects.
- Load-use hazards: one-bubble stall.
- Taken branches and jumps: flush of the two younger stages.
- Multi-cycle data-memory reads and MMIO reads waiting on the confirm button: whole-pipeline freeze.
- Saturating performance counters for stall and flush cycles.

Parameters:
MEM_LAT, 1, data-memory read latency in cycles (1..16); 1 means no freeze.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
ID_rs1_addr  in  5  rs1 of the instruction in ID
ID_rs2_addr  in  5  rs2 of the instruction in ID
ID_uses_rs1  in  1  ID instruction reads rs1
ID_uses_rs2  in  1  ID instruction reads rs2
EX_rs1_addr  in  5  rs1 of the instruction in EX
EX_rs2_addr  in  5  rs2 of the instruction in EX
EX_rd_addr  in  5  destination register in EX
EX_MemRead  in  1  EX instruction is a memory load
EX_ioRead  in  1  EX instruction is an MMIO load
EX_branch_taken  in  1  branch/jump resolved taken in EX
MEM_rd_addr  in  5  destination register in MEM
MEM_RegWrite  in  1  MEM instruction writes a register
MEM_MemRead  in  1  MEM instruction is a memory load
MEM_ioRead  in  1  MEM instruction is an MMIO load
WB_rd_addr  in  5  destination register in WB
WB_RegWrite  in  1  WB instruction writes a register
conf_btn_out  in  1  debounced confirm button (already synchronised)
perf_clr  in  1  synchronous clear of the performance counters
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF_ID
IF_ID_flush  out  1  clear IF_ID
ID_EX_stall  out  1  hold ID_EX
ID_EX_flush  out  1  clear ID_EX
EX_MEM_stall  out  1  hold EX_MEM
MEM_WB_flush  out  1  insert bubble into MEM_WB
fwd_a  out  2  EX operand A select: 00 register file, 01 WB, 10 MEM
fwd_b  out  2  EX operand B select, same encoding as fwd_a
ctrl_state  out  2  FSM state, for debug
stall_cycles  out  CNT_W  saturating count of cycles with PC_stall=1
flush_cycles  out  CNT_W  saturating count of cycles with IF_ID_flush=1

Behaviour:
- Reset (asynchronous, rst high):
  - state=RUN, wait counter=0, conf_prev=0, both perf counters=0.
  - All stall, flush and fwd outputs are 0 while rst is high.
- FSM states:
  - RUN=0: normal operation.
  - MEM_WAIT=1: waiting on a multi-cycle memory read.
  - IO_WAIT=2: waiting on the confirm button.
- freeze (combinational):
  - asserted in RUN when MEM_ioRead=1, or when MEM_MemRead=1 and MEM_LAT>=2;
  - asserted in MEM_WAIT while cnt!=0;
  - asserted in IO_WAIT while there is no rising edge of the button.
- Rising edge of the button: io_rise = conf_btn_out & ~conf_prev, where conf_prev is a register updated every cycle.
- Transitions:
  - RUN -> IO_WAIT when MEM_ioRead (takes priority over MEM_MemRead).
  - RUN -> MEM_WAIT when MEM_MemRead and MEM_LAT>=2; cnt <= MEM_LAT-2.
  - MEM_WAIT: when cnt!=0, decrement cnt. When cnt==0, freeze=0 (release cycle) and go to RUN.
  - IO_WAIT: on io_rise, freeze=0 in that same cycle and go to RUN. There is no timeout.
- Memory-read timing: a load spends exactly MEM_LAT cycles in MEM, with freeze high for the first MEM_LAT-1 of them.
- Priority (highest first):
  1. freeze: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall=1; MEM_WB_flush=1; every other flush=0. A taken branch during freeze is ignored because EX is held and the branch is re-evaluated on release.
  2. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, no stalls. This suppresses a simultaneous load-use stall.
  3. Load-use: (EX_MemRead|EX_ioRead) and EX_rd_addr!=0 and ((ID_uses_rs1 and ID_rs1_addr==EX_rd_addr) or (ID_uses_rs2 and ID_rs2_addr==EX_rd_addr)). Response: PC_stall=1, IF_ID_stall=1, ID_EX_flush=1, for one cycle only, since the load then moves to MEM.
  4. Otherwise all stall and flush outputs are 0.
- Forwarding: purely combinational and independent of freeze.
  - fwd_a=10 if MEM_RegWrite and MEM_rd_addr!=0 and MEM_rd_addr==EX_rs1_addr.
  - Otherwise fwd_a=01 if the same condition holds for WB.
  - Otherwise fwd_a=00.
  - MEM beats WB when both match. fwd_b is computed the same way from EX_rs2_addr.
  - x0 is never forwarded.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - perf_clr zeroes both counters and wins over an increment in the same cycle.
- Reset mid-wait: returns to RUN immediately and drops freeze asynchronously.
- EX_MEM gains a stall input driven by EX_MEM_stall. Flush semantics of all pipeline registers are unchanged.

Decomposition:
- riscv_defs.v gains:
  - FSM state encodings: CTRL_RUN, CTRL_MEM_WAIT, CTRL_IO_WAIT.
  - Forwarding select codes: FWD_RF, FWD_WB, FWD_MEM.
- One combinational sub-module, forwarding_unit, computes fwd_a/fwd_b. It is instantiated once.
- The FSM, hazard priority logic and counters stay in pipeline_hazard_ctrl.

Test Plan:
- lw x5 in EX, ID add reads x5 -> exactly one cycle of PC_stall=IF_ID_stall=ID_EX_flush=1; stall_cycles=1. Same stimulus with rd=x0 -> no stall.
- EX_branch_taken=1 together with a load-use match -> IF_ID_flush=ID_EX_flush=1, PC_stall=0; flush_cycles=1.
- MEM_LAT=4, MEM_MemRead held -> freeze for 3 cycles, released in cycle 4; ctrl_state sequence 0,1,1,1,0.
- MEM_ioRead=1, conf_btn_out low for 10 cycles then high -> freeze for 10 cycles, released in the rise cycle; conf_btn_out held high afterwards does not re-release a following ioRead.
- MEM_rd=WB_rd=EX_rs1=x7, both RegWrite=1 -> fwd_a=10; MEM_RegWrite=0 -> fwd_a=01; EX_rs2=x0 -> fwd_b=00.
- rst pulsed during IO_WAIT -> all outputs 0 immediately, state 0. CNT_W=4 with 20 stalls -> stall_cycles=15; perf_clr -> 0.
